// File: rtl/pellet_score_ctrl.sv
// pellet_score_ctrl
// Sits between the pellet placer and the renderer / score display.
// It requests a pellet position from the placer through its go/done
// handshake and holds that position. It checks Pac-Man's tile against
// the held position on every game tick. On a hit it adds to a 3-digit
// BCD score, pulses eaten and asks the placer for the next position.
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   restart      synchronous: clear the score and re-place the pellet
//   tick         one-cycle game-logic step strobe
//   pac_x/pac_y  Pac-Man tile column / row
//   pellet_x/y   position offered by the placer
//   place_done   placer done pulse
//   place_go     placer go request (one-cycle pulse)
//   place_enable placer enable, high while a placement is in flight
//   pellet_x_q/y latched pellet position
//   pellet_valid latched position is live and drawable
//   eaten        one-cycle pulse when the pellet is consumed
//   score_bcd    score as hundreds/tens/ones BCD digits
//   busy         high in every state except ARMED

module pellet_score_ctrl #(
   parameter int SCORE_INC = 1,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        restart,
   input  logic        tick,
   input  logic [7:0]  pac_x,
   input  logic [6:0]  pac_y,
   input  logic [7:0]  pellet_x,
   input  logic [6:0]  pellet_y,
   input  logic        place_done,
   output logic        place_go,
   output logic        place_enable,
   output logic [7:0]  pellet_x_q,
   output logic [6:0]  pellet_y_q,
   output logic        pellet_valid,
   output logic        eaten,
   output logic [11:0] score_bcd,
   output logic        busy
);

   localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);
   localparam logic [4:0] INC_DIGIT   = 5'(SCORE_INC);

   typedef enum logic [2:0] {
      INIT,
      PLACE_REQ,
      PLACE_WAIT,
      ARMED,
      EATEN
   } ctrlState_t;

   ctrlState_t  state;
   logic [9:0]  waitCount;
   logic [11:0] scoreNext;
   logic [4:0]  onesSum, tensSum, hundSum;
   logic        onesCarry, tensCarry, hundCarry;
   logic [3:0]  onesDigit, tensDigit, hundDigit;
   logic        pacOnPellet;

   // Next score after one pellet. The increment goes into the ones digit
   // and each digit that passes 9 wraps and carries upward. A carry out of
   // the hundreds digit means the score would pass 999, so it pins at 999.
   always_comb begin
      onesSum   = {1'b0, score_bcd[3:0]} + INC_DIGIT;
      onesCarry = (onesSum > 5'd9);
      onesDigit = onesCarry ? 4'(onesSum - 5'd10) : onesSum[3:0];

      tensSum   = {1'b0, score_bcd[7:4]} + {4'd0, onesCarry};
      tensCarry = (tensSum > 5'd9);
      tensDigit = tensCarry ? 4'(tensSum - 5'd10) : tensSum[3:0];

      hundSum   = {1'b0, score_bcd[11:8]} + {4'd0, tensCarry};
      hundCarry = (hundSum > 5'd9);
      hundDigit = hundCarry ? 4'(hundSum - 5'd10) : hundSum[3:0];

      scoreNext = hundCarry ? 12'h999 : {hundDigit, tensDigit, onesDigit};
   end

   // Pac-Man sits on the held pellet tile.
   assign pacOnPellet = (pac_x == pellet_x_q) && (pac_y == pellet_y_q);

   // The only state in which the controller waits for gameplay.
   assign busy = (state != ARMED);

   // Main controller. Outputs are registered together with the state so
   // they always match the state being entered. restart wins over every
   // other synchronous event, so a done pulse or a matching tick that
   // lands on the same edge is dropped. go and eaten are pulses: they
   // default low and are raised only on the edge entering their state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         waitCount    <= '0;
         score_bcd    <= '0;
         pellet_x_q   <= '0;
         pellet_y_q   <= '0;
         place_go     <= 1'b0;
         place_enable <= 1'b0;
         pellet_valid <= 1'b0;
         eaten        <= 1'b0;
      end else if (restart) begin
         state        <= INIT;
         waitCount    <= '0;
         score_bcd    <= '0;
         place_go     <= 1'b0;
         place_enable <= 1'b0;
         pellet_valid <= 1'b0;
         eaten        <= 1'b0;
      end else begin
         place_go <= 1'b0;
         eaten    <= 1'b0;
         case (state)
            INIT: begin
               state        <= PLACE_REQ;
               place_go     <= 1'b1;
               place_enable <= 1'b1;
               pellet_valid <= 1'b0;
            end
            PLACE_REQ: begin
               state        <= PLACE_WAIT;
               waitCount    <= '0;
               place_enable <= 1'b1;
            end
            PLACE_WAIT: begin
               if (place_done) begin
                  state        <= ARMED;
                  pellet_x_q   <= pellet_x;
                  pellet_y_q   <= pellet_y;
                  place_enable <= 1'b0;
                  pellet_valid <= 1'b1;
               end else if (waitCount == TIMEOUT_CNT) begin
                  state        <= PLACE_REQ;
                  place_go     <= 1'b1;
                  place_enable <= 1'b1;
               end else begin
                  waitCount <= waitCount + 10'd1;
               end
            end
            ARMED: begin
               if (tick && pacOnPellet) begin
                  state        <= EATEN;
                  score_bcd    <= scoreNext;
                  pellet_valid <= 1'b0;
                  eaten        <= 1'b1;
               end
            end
            EATEN: begin
               state        <= PLACE_REQ;
               place_go     <= 1'b1;
               place_enable <= 1'b1;
            end
            default: begin
               state        <= INIT;
               place_enable <= 1'b0;
               pellet_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
